// File: rtl/native_sig_delay_pkg.sv
// Shared constants for the native-port signal delay slave: register map,
// CTRL/STATUS field positions and the fixed ID word.
package sig_delay_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DELAY  = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_ID     = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;
    localparam int STATUS_FILL_LSB = 16;

    localparam logic [31:0] ID_VALUE = 32'h5D1E_0001;

endpackage

// File: rtl/native_sig_delay_if.sv
// Native register-access bus driven by the AXI-Lite-to-native bridge.
interface native_sig_delay_if #(
    parameter int NATIVE_ADDR_WIDTH = 2,
    parameter int NATIVE_DATA_WIDTH = 32
);
    logic                         NATIVE_EN;
    logic                         NATIVE_WR;
    logic [NATIVE_ADDR_WIDTH-1:0] NATIVE_ADDR;
    logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_IN;
    logic [NATIVE_DATA_WIDTH-1:0] NATIVE_DATA_OUT;
    logic                         NATIVE_READY;

    modport master (
        output NATIVE_EN, NATIVE_WR, NATIVE_ADDR, NATIVE_DATA_IN,
        input  NATIVE_DATA_OUT, NATIVE_READY
    );

    modport slave (
        input  NATIVE_EN, NATIVE_WR, NATIVE_ADDR, NATIVE_DATA_IN,
        output NATIVE_DATA_OUT, NATIVE_READY
    );
endinterface

// File: rtl/native_sig_delay_line.sv
// Circular-buffer delay line: SIG_IN reappears DELAY+1 cycles later once the
// buffer holds DELAY samples of fresh history; output is zero until then.
module sig_delay_line #(
    parameter int SIG_WIDTH = 16,
    parameter int DLY_W     = 8
) (
    input  logic                 S_AXI_aclk,
    input  logic                 S_AXI_aresetn,
    input  logic                 enable,
    input  logic                 restart,
    input  logic [DLY_W-1:0]     delay,
    input  logic [SIG_WIDTH-1:0] sig_in,
    output logic [SIG_WIDTH-1:0] sig_out,
    output logic                 primed,
    output logic [DLY_W-1:0]     fill
);
    localparam int DEPTH = 2**DLY_W;

    logic [SIG_WIDTH-1:0] mem [DEPTH];
    logic [DLY_W-1:0]     wp_q;
    logic [DLY_W-1:0]     rp;
    logic [DLY_W-1:0]     fill_q;
    logic [SIG_WIDTH-1:0] sig_out_q;
    logic                 primed_q;
    logic [SIG_WIDTH-1:0] tap;
    logic                 go;

    // The read tap is taken before this cycle's write lands, so mem[wp-DELAY]
    // is the sample written DELAY edges ago.
    assign rp  = wp_q - delay;
    assign tap = (delay == '0) ? sig_in : mem[rp];
    assign go  = enable & ~restart & (fill_q == delay);

    // No reset on the storage; stale words are masked by the PRIMED gate.
    always_ff @(posedge S_AXI_aclk) begin
        if (enable) begin
            mem[wp_q] <= sig_in;
        end
    end

    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            wp_q      <= '0;
            fill_q    <= '0;
            primed_q  <= 1'b0;
            sig_out_q <= '0;
        end else begin
            if (enable) begin
                wp_q <= wp_q + 1'b1;
            end
            if (restart || !enable) begin
                fill_q <= '0;
            end else if (fill_q < delay) begin
                fill_q <= fill_q + 1'b1;
            end
            primed_q  <= go;
            sig_out_q <= go ? tap : '0;
        end
    end

    assign sig_out = sig_out_q;
    assign primed  = primed_q;
    assign fill    = fill_q;

endmodule

// File: rtl/native_sig_delay.sv
// Native-port register slave (CTRL/DELAY/STATUS/ID) in front of a
// programmable delay line; every access completes with a one-cycle READY.
module native_sig_delay
    import sig_delay_pkg::*;
#(
    parameter int NATIVE_ADDR_WIDTH = 2,
    parameter int NATIVE_DATA_WIDTH = 32,
    parameter int SIG_WIDTH         = 16,
    parameter int DLY_W             = 8
) (
    input  logic                 S_AXI_aclk,
    input  logic                 S_AXI_aresetn,
    native_sig_delay_if.slave    nat,
    input  logic [SIG_WIDTH-1:0] SIG_IN,
    output logic [SIG_WIDTH-1:0] SIG_OUT,
    output logic                 SIG_PRIMED
);
    logic                         wr_acc;
    logic                         rd_acc;
    logic                         sel_ctrl;
    logic                         sel_delay;
    logic                         restart;
    logic                         enable_q;
    logic [DLY_W-1:0]             delay_q;
    logic [DLY_W-1:0]             fill;
    logic                         primed;
    logic [NATIVE_DATA_WIDTH-1:0] rd_data;
    logic [NATIVE_DATA_WIDTH-1:0] data_out_q;
    logic                         ready_q;
    logic                         unused_wdata;

    assign wr_acc    = nat.NATIVE_EN &  nat.NATIVE_WR;
    assign rd_acc    = nat.NATIVE_EN & ~nat.NATIVE_WR;
    assign sel_ctrl  = (nat.NATIVE_ADDR == NATIVE_ADDR_WIDTH'(ADDR_CTRL));
    assign sel_delay = (nat.NATIVE_ADDR == NATIVE_ADDR_WIDTH'(ADDR_DELAY));

    // Any DELAY write, a FLUSH, or a rising ENABLE discards history.
    assign restart = wr_acc & (sel_delay |
                     (sel_ctrl & (nat.NATIVE_DATA_IN[CTRL_FLUSH_BIT] |
                                  (nat.NATIVE_DATA_IN[CTRL_ENABLE_BIT] & ~enable_q))));

    assign unused_wdata = ^nat.NATIVE_DATA_IN[NATIVE_DATA_WIDTH-1:DLY_W];

    always_comb begin
        rd_data = '0;
        case (nat.NATIVE_ADDR)
            NATIVE_ADDR_WIDTH'(ADDR_CTRL):   rd_data[CTRL_ENABLE_BIT] = enable_q;
            NATIVE_ADDR_WIDTH'(ADDR_DELAY):  rd_data[DLY_W-1:0] = delay_q;
            NATIVE_ADDR_WIDTH'(ADDR_STATUS): begin
                rd_data[0]                        = primed;
                rd_data[STATUS_FILL_LSB +: DLY_W] = fill;
            end
            NATIVE_ADDR_WIDTH'(ADDR_ID):     rd_data = NATIVE_DATA_WIDTH'(ID_VALUE);
            default:                         rd_data = '0;
        endcase
    end

    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            enable_q <= 1'b0;
            delay_q  <= '0;
        end else if (wr_acc) begin
            if (sel_ctrl) begin
                enable_q <= nat.NATIVE_DATA_IN[CTRL_ENABLE_BIT];
            end
            if (sel_delay) begin
                delay_q <= nat.NATIVE_DATA_IN[DLY_W-1:0];
            end
        end
    end

    // READY follows EN by one edge with no holding, so back-to-back accesses
    // produce back-to-back pulses.
    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            ready_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            ready_q    <= nat.NATIVE_EN;
            data_out_q <= rd_acc ? rd_data : '0;
        end
    end

    assign nat.NATIVE_READY    = ready_q;
    assign nat.NATIVE_DATA_OUT = data_out_q;

    sig_delay_line #(
        .SIG_WIDTH (SIG_WIDTH),
        .DLY_W     (DLY_W)
    ) u_line (
        .S_AXI_aclk    (S_AXI_aclk),
        .S_AXI_aresetn (S_AXI_aresetn),
        .enable        (enable_q),
        .restart       (restart),
        .delay         (delay_q),
        .sig_in        (SIG_IN),
        .sig_out       (SIG_OUT),
        .primed        (SIG_PRIMED),
        .fill          (fill)
    );

    assign primed = SIG_PRIMED;

endmodule

// File: tb/tb_native_sig_delay.sv
// Bench for native_sig_delay: register table, directed delay/restart sequences
// and random traffic checked against a sample-history reference model.
module tb_native_sig_delay;
    import sig_delay_pkg::*;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam int SW = 16;
    localparam int DLY_W = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] sig_in;
    logic [SW-1:0] sig_out;
    logic          primed;

    always #5 clk = ~clk;

    native_sig_delay_if #(.NATIVE_ADDR_WIDTH(AW), .NATIVE_DATA_WIDTH(DW)) nat ();

    native_sig_delay #(
        .NATIVE_ADDR_WIDTH (AW),
        .NATIVE_DATA_WIDTH (DW),
        .SIG_WIDTH         (SW),
        .DLY_W             (DLY_W)
    ) dut (
        .S_AXI_aclk    (clk),
        .S_AXI_aresetn (rst_n),
        .nat           (nat),
        .SIG_IN        (sig_in),
        .SIG_OUT       (sig_out),
        .SIG_PRIMED    (primed)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: registers plus a history of every sample written.
    bit            m_en;
    int            m_dly;
    int            m_k;
    int            m_fill;
    bit            m_primed;
    logic [SW-1:0] m_out;
    logic [SW-1:0] hist[$];

    typedef struct {
        bit          en;
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] data;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_dly = 0; m_k = 0; m_fill = 0; m_primed = 0; m_out = '0;
        hist.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] addr);
        case (addr)
            ADDR_CTRL:   return {31'd0, m_en};
            ADDR_DELAY:  return 32'(m_dly);
            ADDR_STATUS: return (32'(m_fill) << STATUS_FILL_LSB) | {31'd0, m_primed};
            default:     return ID_VALUE;
        endcase
    endfunction

    // One clock: drive access + sample, advance the model, check all outputs.
    task automatic step(input bit en, input bit wr, input logic [1:0] addr,
                        input logic [31:0] data, input logic [SW-1:0] sig,
                        output logic [31:0] rd);
        logic [31:0] exp_rd;
        bit          rs;
        nat.NATIVE_EN      = en;
        nat.NATIVE_WR      = wr;
        nat.NATIVE_ADDR    = addr;
        nat.NATIVE_DATA_IN = data;
        sig_in             = sig;
        exp_rd = model_read(addr);
        rs = en && wr && (addr == ADDR_DELAY ||
                          (addr == ADDR_CTRL && (data[1] || (data[0] && !m_en))));
        if (m_en) begin
            hist.push_back(sig);
            if (hist.size() > 400) void'(hist.pop_front());
        end
        if (rs || !m_en) begin
            m_k = 0; m_primed = 0; m_out = '0;
        end else begin
            m_primed = (m_k >= m_dly);
            m_out = m_primed ? hist[hist.size() - 1 - m_dly] : '0;
            m_k++;
        end
        m_fill = (m_k < m_dly) ? m_k : m_dly;
        if (en && wr && addr == ADDR_CTRL)  m_en  = data[0];
        if (en && wr && addr == ADDR_DELAY) m_dly = int'(data[DLY_W-1:0]);
        @(posedge clk);
        #1;
        rd = nat.NATIVE_DATA_OUT;
        check("ready", {31'd0, nat.NATIVE_READY}, {31'd0, en});
        if (en && !wr) check("rdata", nat.NATIVE_DATA_OUT, exp_rd);
        check("sig_out", {16'd0, sig_out}, {16'd0, m_out});
        check("primed", {31'd0, primed}, {31'd0, m_primed});
    endtask

    task automatic idle(input logic [SW-1:0] sig);
        logic [31:0] d;
        step(0, 0, 2'd0, 32'd0, sig, d);
    endtask

    initial begin
        logic [31:0] rd;
        int          rise_at;
        int          r;

        nat.NATIVE_EN = 0; nat.NATIVE_WR = 0; nat.NATIVE_ADDR = '0; nat.NATIVE_DATA_IN = '0;
        sig_in = 16'hABCD;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_sig_out", {16'd0, sig_out}, 32'd0);
        check("rst_primed", {31'd0, primed}, 32'd0);
        check("rst_ready", {31'd0, nat.NATIVE_READY}, 32'd0);
        check("rst_dout", nat.NATIVE_DATA_OUT, 32'd0);
        rst_n = 1'b1;

        tbl[0]  = '{1, 0, ADDR_ID,     32'h0,         1, ID_VALUE};
        tbl[1]  = '{1, 1, ADDR_DELAY,  32'h1FF,       0, 32'h0};
        tbl[2]  = '{1, 0, ADDR_DELAY,  32'h0,         1, 32'hFF};
        tbl[3]  = '{1, 1, ADDR_STATUS, 32'hFFFF_FFFF, 0, 32'h0};
        tbl[4]  = '{1, 0, ADDR_STATUS, 32'h0,         1, 32'h0};
        tbl[5]  = '{1, 1, ADDR_ID,     32'h0,         0, 32'h0};
        tbl[6]  = '{1, 0, ADDR_ID,     32'h0,         1, ID_VALUE};
        tbl[7]  = '{1, 1, ADDR_CTRL,   32'h3,         0, 32'h0};
        tbl[8]  = '{1, 0, ADDR_CTRL,   32'h0,         1, 32'h1};
        tbl[9]  = '{1, 1, ADDR_CTRL,   32'h0,         0, 32'h0};
        tbl[10] = '{1, 0, ADDR_CTRL,   32'h0,         1, 32'h0};
        tbl[11] = '{1, 1, ADDR_DELAY,  32'h0,         0, 32'h0};
        tbl[12] = '{1, 0, ADDR_DELAY,  32'h0,         1, 32'h0};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].data, 16'(i), rd);
            if (tbl[i].chk) check("table_rd", rd, tbl[i].exp);
        end

        // DELAY=5 ramp: PRIMED rises 6 edges after the enabling write.
        step(1, 1, ADDR_DELAY, 32'd5, 16'd0, rd);
        rise_at = -1;
        step(1, 1, ADDR_CTRL, 32'd1, 16'd1, rd);
        for (int j = 1; j <= 20; j++) begin
            idle(16'(j + 1));
            if (primed && rise_at < 0) rise_at = j;
            if (j >= 6) check("ramp5_data", {16'd0, sig_out}, 32'(j - 4));
        end
        check("ramp5_rise", 32'(rise_at), 32'd6);

        // DELAY=0: output is the sample taken on the same edge.
        step(1, 1, ADDR_DELAY, 32'd0, 16'h0100, rd);
        for (int j = 1; j <= 10; j++) begin
            idle(16'h0100 + 16'(j));
            check("dly0_data", {16'd0, sig_out}, 32'h0100 + 32'(j));
        end

        // DELAY=255 across pointer wrap, then FILL/PRIMED via STATUS.
        step(1, 1, ADDR_DELAY, 32'd255, 16'd0, rd);
        for (int j = 1; j <= 600; j++) idle(16'(j * 3));
        step(1, 0, ADDR_STATUS, 32'd0, 16'd7, rd);
        check("status_255", rd, (32'd255 << 16) | 32'd1);

        // Restart by DELAY write, then by FLUSH.
        step(1, 1, ADDR_DELAY, 32'd10, 16'd0, rd);
        for (int j = 1; j <= 30; j++) idle(16'h2000 + 16'(j));
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) step(1, 1, ADDR_DELAY, 32'd3, 16'h3000, rd);
            else           step(1, 1, ADDR_CTRL,  32'd3, 16'h3000, rd);
            check("restart_gate0", {15'd0, primed, sig_out}, 32'd0);
            for (int j = 1; j <= 3; j++) begin
                idle(16'h3000 + 16'(j));
                check("restart_gate", {15'd0, primed, sig_out}, 32'd0);
            end
            for (int j = 4; j <= 10; j++) begin
                idle(16'h3000 + 16'(j));
                check("restart_data", {15'd0, primed, sig_out}, 32'h1_3000 + 32'(j - 3));
            end
        end

        // Random accesses mixed with random samples.
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            case (r)
                0: step(1, 1, ADDR_DELAY, $urandom_range(0, 12), 16'($urandom), rd);
                1: step(1, 1, ADDR_CTRL, {30'd0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0)},
                        16'($urandom), rd);
                2: step(1, 0, ADDR_STATUS, 32'd0, 16'($urandom), rd);
                3: step(1, $urandom_range(0, 1) == 1, 2'($urandom_range(2, 3)), $urandom, 16'($urandom), rd);
                default: idle(16'($urandom));
            endcase
        end

        // Back-to-back accesses, then reset with a READY pending.
        step(1, 1, ADDR_CTRL, 32'd1, 16'd0, rd);
        step(1, 0, ADDR_CTRL, 32'd0, 16'd1, rd);
        step(1, 1, ADDR_DELAY, 32'd7, 16'd2, rd);
        step(1, 0, ADDR_DELAY, 32'd0, 16'd3, rd);
        check("pipe_rd", rd, 32'd7);
        for (int j = 0; j < 12; j++) idle(16'h4000 + 16'(j));
        check("pre_rst_primed", {31'd0, primed}, 32'd1);
        nat.NATIVE_EN = 1; nat.NATIVE_WR = 0; nat.NATIVE_ADDR = ADDR_ID;
        @(posedge clk);
        #1;
        nat.NATIVE_EN = 0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, nat.NATIVE_READY}, 32'd0);
        check("midrst_dout", nat.NATIVE_DATA_OUT, 32'd0);
        check("midrst_sig", {15'd0, primed, sig_out}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_ready2", {31'd0, nat.NATIVE_READY}, 32'd0);
        rst_n = 1'b1;
        model_reset();
        idle(16'h5555);
        step(1, 0, ADDR_DELAY, 32'd0, 16'h5556, rd);
        check("post_rst_delay", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/native_sig_delay.md
# native_sig_delay

Native-port register slave and programmable signal delay line; sits directly downstream of the AXI-Lite-to-native bridge in the AXI_Sig_Delay IP and consumes its EN/WR/ADDR/DATA_IN strobes. Software configures enable and delay depth through four word registers. A SIG_WIDTH-bit input bus is delayed by DELAY+1 cycles through a circular buffer. The output is gated to zero until the buffer holds enough history.

## Interface
Parameters:
- NATIVE_ADDR_WIDTH, 2, word-address width; 4 registers.
- NATIVE_DATA_WIDTH, 32, register data width.
- SIG_WIDTH, 16, width of the delayed bus.
- DLY_W, 8, delay-field width; buffer depth 2**DLY_W; MAX_DELAY = 2**DLY_W-1.

Ports:
- S_AXI_aclk  in  1  single clock; same net as the bridge NATIVE_CLK.
- S_AXI_aresetn  in  1  asynchronous, active-low reset.
- NATIVE_EN  in  1  one-cycle access strobe.
- NATIVE_WR  in  1  1 = write, 0 = read; valid while NATIVE_EN=1.
- NATIVE_ADDR  in  NATIVE_ADDR_WIDTH  word address.
- NATIVE_DATA_IN  in  NATIVE_DATA_WIDTH  write data.
- NATIVE_DATA_OUT  out  NATIVE_DATA_WIDTH  read data; valid in the NATIVE_READY cycle.
- NATIVE_READY  out  1  one-cycle completion pulse.
- SIG_IN  in  SIG_WIDTH  bus to delay.
- SIG_OUT  out  SIG_WIDTH  delayed bus (registered).
- SIG_PRIMED  out  1  1 when SIG_OUT carries valid delayed data.

## Operation
Register map (word addresses):
- 0 CTRL, RW.
  - bit0 ENABLE.
  - bit1 FLUSH: write-1 pulse, always reads 0.
- 1 DELAY, RW, [DLY_W-1:0]; upper bits ignored and read 0.
- 2 STATUS, RO.
  - bit0 PRIMED.
  - [16+:DLY_W] FILL count.
- 3 ID, RO, constant 32'h5D1E_0001.

Write and field rules:
- Writes to STATUS and ID are ignored, but still complete with a READY pulse.
- All writes are full-word.

Delay line:
- While ENABLE=1, every cycle writes SIG_IN to mem[wp] and increments wp (wraps mod 2**DLY_W).
- DELAY=0: next SIG_OUT = SIG_IN.
- DELAY>0: next SIG_OUT = mem[wp-DELAY] (mod 2**DLY_W).
- FILL increments each enabled cycle, saturating at DELAY.
- PRIMED = ENABLE && (FILL == DELAY), registered alongside SIG_OUT.
- SIG_OUT is forced to 0 whenever PRIMED=0.

Restart events: each of the following clears FILL and PRIMED on the next edge; wp is unchanged and memory is not cleared.
- Write to DELAY, even with the same value.
- FLUSH write.
- ENABLE written 0→1.

Other behaviour:
- While ENABLE=0: no buffer writes, FILL=0, SIG_OUT=0.
- The memory has no reset; gating by PRIMED hides stale contents.

## Timing
- Access latency: NATIVE_EN sampled at edge N gives NATIVE_READY=1 for exactly the cycle after edge N.
- Read data: NATIVE_DATA_OUT is registered and valid in that same READY cycle.
- Write effect: register update is visible at edge N.
- NATIVE_READY is never held high beyond one cycle, because the bridge raises a response for each READY-high cycle.
- Accesses are fully pipelined: EN on consecutive cycles gives READY on consecutive cycles. There is no busy state.
- Signal path: SIG_IN sampled at edge t appears on SIG_OUT after edge t+DELAY, i.e. latency DELAY+1 cycles once PRIMED.
- Priming: after a restart, PRIMED rises DELAY+1 edges later. DELAY=0 primes after 1 edge.
- Simultaneous events: a DELAY write in the same cycle as FILL would reach DELAY → restart wins; PRIMED stays 0.
- Reset values, all asynchronous:
  - CTRL=0, DELAY=0, wp=0, FILL=0.
  - SIG_OUT=0, SIG_PRIMED=0.
  - NATIVE_READY=0, NATIVE_DATA_OUT=0.
- Reset asserted mid-access: the pending READY is dropped.

## Structure
- Package sig_delay_pkg holds:
  - address constants ADDR_CTRL/ADDR_DELAY/ADDR_STATUS/ADDR_ID;
  - bit indices CTRL_ENABLE_BIT and CTRL_FLUSH_BIT;
  - STATUS_FILL_LSB=16;
  - ID_VALUE.
- Sub-module sig_delay_line: memory, wp, FILL, PRIMED gating and the SIG_OUT register. Inputs are enable, delay and restart.
- Top level holds the register decode, READY/DATA_OUT pipeline and restart generation.

## Test plan
- Reset: hold S_AXI_aresetn low → all outputs 0; read ID → 32'h5D1E_0001 with READY one cycle after EN.
- Register path:
  - Write DELAY=0x1FF → read back 0xFF.
  - Write STATUS=0xFFFF_FFFF → STATUS unchanged, READY still pulses once.
- Delay accuracy: DELAY=5, ENABLE=1, SIG_IN ramps 1,2,3… from cycle 0 → PRIMED rises after 6 edges, and SIG_OUT equals SIG_IN from 6 cycles earlier thereafter.
- Boundaries:
  - DELAY=0 → SIG_OUT follows SIG_IN with 1-cycle latency.
  - DELAY=255 with a 600-cycle ramp → correct across wp wrap; FILL reads 255.
- Restart: while primed at DELAY=10, write DELAY=3 → PRIMED=0 and SIG_OUT=0 for 4 edges, then a 4-cycle-latency stream. Same check with FLUSH.
- Pipelined access and reset: EN on 3 consecutive cycles (read CTRL, write DELAY=7, read DELAY) → 3 consecutive READY pulses, last data 7. Then assert reset mid-stream → outputs clear immediately and no READY is emitted.
